uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx_if.sv | 19 +
 rtl/uart_frame_rx.sv | 152 +++++++++++++++
 tb/tb_uart_frame_rx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: held-frame handshake bundle; master = receiver (rx_valid/rx_done/data_byte/status out, rx_ready in), slave = consumer
interface uart_frame_rx_if;
  logic       rx_done;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] data_byte;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun;
  modport master (
    output rx_done, rx_valid, data_byte, parity_err, frame_err, break_det, overrun,
    input  rx_ready
  );
  modport slave (
    input  rx_done, rx_valid, data_byte, parity_err, frame_err, break_det, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 16x-oversampled UART frame receiver; mclk/rst_n, frame config (baud_div, data_bits, parity_mode, stop2) latched per frame, rs232_rx line in, uart_state busy out, held frame + status on rx (master)
module uart_frame_rx #(
  parameter int DIV_W = 16,
  parameter int OVS   = 16
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  input  logic             rs232_rx,
  output logic             uart_state,
  uart_frame_rx_if.master  rx
);
  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] T_A    = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_B    = TW'(OVS / 2);
  localparam logic [TW-1:0] T_C    = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;
  logic             s1, s2, s_prev;
  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt, bd_l;
  logic [TW-1:0]    tcnt;
  logic [1:0]       db_l, pm_l;
  logic             st2_l;
  logic [2:0]       bcnt;
  logic [7:0]       sh;
  logic             par, allz, ferr, m7, m8;
  logic             start_det, tick, mid, last, maj, par_en, last_bit, fin, brk_n;
  always_comb begin
    start_det = state == IDLE && s_prev && !s2;
    tick      = state != IDLE && div_cnt == bd_l;
    mid       = tick && tcnt == T_C;
    last      = tick && tcnt == T_LAST;
    maj       = (m7 & m8) | (m7 & s2) | (m8 & s2);
    par_en    = pm_l[0] ^ pm_l[1];
    last_bit  = bcnt == {1'b0, db_l} + 3'd4;
    fin       = mid && (state == STOP2 || (state == STOP1 && !st2_l));
    // stop bit 1 only joins the break test while it is still being sampled
    brk_n     = state == STOP1 ? allz & ~maj : allz;
  end
  assign uart_state = state != IDLE;
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s_prev  <= 1'b1;
      state   <= IDLE;
      div_cnt <= '0;
      tcnt    <= '0;
      bcnt    <= '0;
      bd_l    <= '0;
      db_l    <= '0;
      pm_l    <= '0;
      st2_l   <= 1'b0;
      sh      <= '0;
      par     <= 1'b0;
      allz    <= 1'b0;
      ferr    <= 1'b0;
      m7      <= 1'b0;
      m8      <= 1'b0;
    end else begin
      s1     <= rs232_rx;
      s2     <= s1;
      s_prev <= s2;
      if (start_det) begin
        state   <= START;
        div_cnt <= '0;
        tcnt    <= '0;
        bcnt    <= '0;
        bd_l    <= baud_div;
        db_l    <= data_bits;
        pm_l    <= parity_mode;
        st2_l   <= stop2;
        sh      <= '0;
        par     <= 1'b0;
        allz    <= 1'b1;
        ferr    <= 1'b0;
      end else if (state != IDLE) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick) tcnt <= tcnt + TW'(1);
        if (tick && tcnt == T_A) m7 <= s2;
        if (tick && tcnt == T_B) m8 <= s2;
        case (state)
          START: begin
            if (mid && maj) state <= IDLE;
            else if (last) state <= DATA;
          end
          DATA: begin
            if (mid) begin
              sh[bcnt] <= maj;
              par      <= par ^ maj;
              allz     <= allz & ~maj;
            end
            if (last) begin
              if (last_bit) state <= par_en ? PARITY : STOP1;
              else bcnt <= bcnt + 3'd1;
            end
          end
          PARITY: begin
            if (mid) begin
              par  <= par ^ maj;
              allz <= allz & ~maj;
            end
            if (last) state <= STOP1;
          end
          STOP1: begin
            if (mid) begin
              ferr <= ~maj;
              allz <= allz & ~maj;
              if (!st2_l) state <= IDLE;
            end
            if (last && st2_l) state <= STOP2;
          end
          STOP2: if (mid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rx.rx_done    <= 1'b0;
      rx.rx_valid   <= 1'b0;
      rx.data_byte  <= '0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.break_det  <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.rx_done <= fin;
      if (fin) begin
        rx.rx_valid   <= 1'b1;
        rx.data_byte  <= sh;
        rx.parity_err <= par_en & (par ^ pm_l[1]);
        rx.frame_err  <= ferr | ~maj;
        rx.break_det  <= brk_n;
        rx.overrun    <= rx.rx_valid & ~rx.rx_ready;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
        rx.overrun  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: randomized line-level stimulus for uart_frame_rx checked against a frame-level reference model
module tb_uart_frame_rx;
  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div;
  logic [1:0]  data_bits, parity_mode;
  logic        stop2, rs232_rx, uart_state;
  uart_frame_rx_if rx_if();
  uart_frame_rx dut (
    .mclk(mclk),
    .rst_n(rst_n),
    .baud_div(baud_div),
    .data_bits(data_bits),
    .parity_mode(parity_mode),
    .stop2(stop2),
    .rs232_rx(rs232_rx),
    .uart_state(uart_state),
    .rx(rx_if)
  );
  always #5 mclk = ~mclk;
  int n_tests = 0, n_fail = 0, done_cnt = 0, d_save;
  int c_bd;
  logic [1:0] c_db, c_pm;
  logic c_st2, exp_valid, exp_ovr;
  always @(negedge mclk) if (rx_if.rx_done) done_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic apply_cfg();
    baud_div    = 16'(c_bd);
    data_bits   = c_db;
    parity_mode = c_pm;
    stop2       = c_st2;
  endtask
  task automatic chk_all_zero(input string tag);
    chk(tag, {uart_state, rx_if.rx_done, rx_if.rx_valid, rx_if.data_byte, rx_if.parity_err,
              rx_if.frame_err, rx_if.break_det, rx_if.overrun}, 0);
  endtask
  task automatic idle(input int n);
    @(negedge mclk) rs232_rx = 1'b1;
    repeat (n) @(negedge mclk);
  endtask
  task automatic pulse_ready();
    @(negedge mclk) rx_if.rx_ready = 1'b1;
    @(negedge mclk) rx_if.rx_ready = 1'b0;
    @(negedge mclk);
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    chk("ready_valid", rx_if.rx_valid, exp_valid);
    chk("ready_ovr", rx_if.overrun, exp_ovr);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic [1:0] sb, input int abort_bit);
    logic bits[$];
    int nb, per, d0, ones;
    logic pe, ep, ef, eb;
    logic [7:0] ed;
    nb  = int'(c_db) + 5;
    pe  = c_pm == 2'd1 || c_pm == 2'd2;
    per = 16 * (c_bd + 1);
    d0  = done_cnt;
    apply_cfg();
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(sb[0]);
    if (c_st2) bits.push_back(sb[1]);
    for (int k = 0; k < bits.size(); k++) begin
      @(negedge mclk) rs232_rx = bits[k];
      if (k == 1) begin
        baud_div    = 16'($urandom);
        data_bits   = 2'($urandom);
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
      end
      if (k == abort_bit) begin
        repeat (per / 2) @(negedge mclk);
        rst_n    = 1'b0;
        rs232_rx = 1'b1;
        repeat (3) @(negedge mclk);
        chk_all_zero("reset_mid_frame");
        rst_n = 1'b1;
        apply_cfg();
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        repeat (per) @(negedge mclk);
        chk("reset_no_done", done_cnt - d0, 0);
        return;
      end
      repeat (per - 1) @(negedge mclk);
    end
    @(negedge mclk) rs232_rx = 1'b1;
    apply_cfg();
    ed   = d & 8'((1 << nb) - 1);
    ones = $countones(ed) + ((pe && pb) ? 1 : 0);
    ep   = pe && (c_pm == 2'd1 ? ones % 2 != 0 : ones % 2 == 0);
    ef   = !sb[0] || (c_st2 && !sb[1]);
    eb   = ed == 0 && !(pe && pb) && !sb[0];
    exp_ovr   = exp_valid;
    exp_valid = 1'b1;
    chk("done_count", done_cnt - d0, 1);
    chk("data_byte", rx_if.data_byte, ed);
    chk("parity_err", rx_if.parity_err, ep);
    chk("frame_err", rx_if.frame_err, ef);
    chk("break_det", rx_if.break_det, eb);
    chk("rx_valid", rx_if.rx_valid, exp_valid);
    chk("overrun", rx_if.overrun, exp_ovr);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rs232_rx = 1'b1;
    rx_if.rx_ready = 1'b0;
    c_bd = 0; c_db = 2'd3; c_pm = 2'd0; c_st2 = 1'b0;
    apply_cfg();
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    repeat (3) @(negedge mclk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    repeat (5) @(negedge mclk);
    send_frame(8'hA5, 1'b0, 2'b11, -1);
    pulse_ready();
    c_db = 2'd2; c_pm = 2'd1;
    send_frame(8'h35, 1'b1, 2'b11, -1);
    pulse_ready();
    c_db = 2'd3; c_pm = 2'd0;
    apply_cfg();
    d_save = done_cnt;
    @(negedge mclk) rs232_rx = 1'b0;
    repeat (4) @(negedge mclk);
    @(negedge mclk) rs232_rx = 1'b1;
    chk("false_start_busy", uart_state, 1);
    for (int i = 0; i < 64 && uart_state; i++) @(negedge mclk);
    chk("false_start_idle", uart_state, 0);
    chk("false_start_no_done", done_cnt - d_save, 0);
    idle(20);
    send_frame(8'h00, 1'b0, 2'b00, -1);
    idle(16);
    pulse_ready();
    c_st2 = 1'b1;
    send_frame(8'h11, 1'b0, 2'b11, -1);
    send_frame(8'h22, 1'b0, 2'b11, -1);
    pulse_ready();
    c_st2 = 1'b0;
    send_frame(8'h5A, 1'b0, 2'b11, 4);
    send_frame(8'h3C, 1'b0, 2'b11, -1);
    pulse_ready();
    for (int n = 0; n < 40; n++) begin
      c_bd  = int'($urandom_range(0, 3));
      c_db  = 2'($urandom);
      c_pm  = 2'($urandom);
      c_st2 = 1'($urandom);
      send_frame(8'($urandom), 1'($urandom), {$urandom_range(0, 6) != 0, $urandom_range(0, 6) != 0}, -1);
      idle(16 * (c_bd + 1));
      if ($urandom_range(0, 1) == 1) pulse_ready();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
